// File: rtl/mips_mem_responder_if.sv
// Request/response bus between a multicycle MIPS core and its memory responder.
// The core drives req_*; the responder drives req_ready, rsp_* and stall.
interface mips_mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Single-port word RAM that serves one core request at a time with a fixed access
// latency; misaligned or out-of-range requests are answered immediately with an error.
module mips_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

  logic                addr_err;
  logic                access;

  always_comb begin
    addr_err = (bus.req_addr[1:0] != 2'b00) || ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
    access   = (state_q == WAIT) && (cnt_q == 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The request is captured on accept so the core may change its inputs freely afterwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          idx_d   = bus.req_addr[ADDR_W+1:2];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          err_d   = addr_err;
          rdata_d = 32'd0;
          if (addr_err) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          rdata_d = write_q ? 32'd0 : mem_q[idx_q];
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = (state_q == RESP) && err_q;
    bus.stall     = (state_q != IDLE) || bus.req_valid;
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (access && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed self-checking bench for mips_mem_responder at LATENCY 2, 1 and 15.
module tb_mips_mem_responder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic        o_ready;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_stall;

  mips_mem_responder_if bus0 ();
  mips_mem_responder_if bus1 ();
  mips_mem_responder_if bus15 ();

  mips_mem_responder #(.ADDR_W(10), .LATENCY(2))  dut   (.clk(clk), .reset(reset), .bus(bus0));
  mips_mem_responder #(.ADDR_W(10), .LATENCY(1))  dut1  (.clk(clk), .reset(reset), .bus(bus1));
  mips_mem_responder #(.ADDR_W(10), .LATENCY(15)) dut15 (.clk(clk), .reset(reset), .bus(bus15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    case (sel)
      1: begin
        bus1.req_valid = v; bus1.req_write = wr; bus1.req_addr = addr;
        bus1.req_wdata = wdata; bus1.req_be = be;
      end
      2: begin
        bus15.req_valid = v; bus15.req_write = wr; bus15.req_addr = addr;
        bus15.req_wdata = wdata; bus15.req_be = be;
      end
      default: begin
        bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = addr;
        bus0.req_wdata = wdata; bus0.req_be = be;
      end
    endcase
  endtask

  task automatic sample(input int sel);
    case (sel)
      1: begin
        o_ready = bus1.req_ready; o_valid = bus1.rsp_valid; o_rdata = bus1.rsp_rdata;
        o_err = bus1.rsp_err; o_stall = bus1.stall;
      end
      2: begin
        o_ready = bus15.req_ready; o_valid = bus15.rsp_valid; o_rdata = bus15.rsp_rdata;
        o_err = bus15.rsp_err; o_stall = bus15.stall;
      end
      default: begin
        o_ready = bus0.req_ready; o_valid = bus0.rsp_valid; o_rdata = bus0.rsp_rdata;
        o_err = bus0.rsp_err; o_stall = bus0.stall;
      end
    endcase
  endtask

  // One full transaction: accept cycle, lat cycles to the response, then one idle cycle.
  task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int lat,
                        input logic exp_err, input logic [31:0] exp_rdata, input string tag);
    @(posedge clk); #1;
    drive(sel, 1'b1, wr, addr, wdata, be);
    @(negedge clk); sample(sel);
    check1({tag, ".acc_ready"}, o_ready, 1'b1);
    check1({tag, ".acc_stall"}, o_stall, 1'b1);
    check1({tag, ".acc_valid"}, o_valid, 1'b0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      drive(sel, 1'b0, ~wr, ~addr, ~wdata, ~be);
      @(negedge clk); sample(sel);
      check1({tag, ".busy_stall"}, o_stall, 1'b1);
      check1({tag, ".busy_ready"}, o_ready, 1'b0);
      if (c < lat) begin
        check1({tag, ".early_valid"}, o_valid, 1'b0);
      end else begin
        check1({tag, ".rsp_valid"}, o_valid, 1'b1);
        check1({tag, ".rsp_err"}, o_err, exp_err);
        check32({tag, ".rsp_rdata"}, o_rdata, exp_rdata);
      end
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); sample(sel);
    check1({tag, ".post_valid"}, o_valid, 1'b0);
    check1({tag, ".post_ready"}, o_ready, 1'b1);
    check1({tag, ".post_stall"}, o_stall, 1'b0);
    check1({tag, ".post_err"}, o_err, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset state, including stall following req_valid while idle
    @(negedge clk); sample(0);
    check1("rst.ready", o_ready, 1'b1);
    check1("rst.valid", o_valid, 1'b0);
    check32("rst.rdata", o_rdata, 32'd0);
    check1("rst.err", o_err, 1'b0);
    check1("rst.stall0", o_stall, 1'b0);
    drive(0, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
    #1; sample(0);
    check1("rst.stall1", o_stall, 1'b1);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic store then load, LATENCY=2
    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 1'b0, 32'd0, "st10");
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 32'hDEADBEEF, "ld10");

    // Byte enables and the be=0000 no-op
    do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 3, 1'b0, 32'd0, "st20");
    do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3, 1'b0, 32'd0, "st20be");
    do_req(0, 1'b0, 32'h20, 32'd0, 4'h0, 3, 1'b0, 32'h11BB33DD, "ld20be");
    do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 3, 1'b0, 32'd0, "st20nop");
    do_req(0, 1'b0, 32'h20, 32'd0, 4'h0, 3, 1'b0, 32'h11BB33DD, "ld20nop");

    // Erroneous requests answer next cycle and leave RAM untouched (0x1010 aliases word 0x10)
    do_req(0, 1'b0, 32'h13, 32'd0, 4'h0, 1, 1'b1, 32'd0, "ldmis");
    do_req(0, 1'b1, 32'h12, 32'h01020304, 4'hF, 1, 1'b1, 32'd0, "stmis");
    do_req(0, 1'b0, 32'h00001000, 32'd0, 4'h0, 1, 1'b1, 32'd0, "ldoor");
    do_req(0, 1'b1, 32'h00001010, 32'h12345678, 4'hF, 1, 1'b1, 32'd0, "stoor");
    do_req(0, 1'b0, 32'h10, 32'd0, 4'h0, 3, 1'b0, 32'hDEADBEEF, "ld10keep");

    // Continuous req_valid with an address that moves every cycle
    do_req(0, 1'b1, 32'h100, 32'hA0000000, 4'hF, 3, 1'b0, 32'd0, "pre100");
    do_req(0, 1'b1, 32'h110, 32'hA0000004, 4'hF, 3, 1'b0, 32'd0, "pre110");
    do_req(0, 1'b1, 32'h120, 32'hA0000008, 4'hF, 3, 1'b0, 32'd0, "pre120");
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b0, 32'h100 + 32'(4 * c), 32'd0, 4'd0);
      @(negedge clk); sample(0);
      check1("hs.stall", o_stall, 1'b1);
      check1("hs.ready", o_ready, (c % 4) == 0);
      check1("hs.valid", o_valid, (c % 4) == 3);
      if ((c % 4) == 3) begin
        check1("hs.err", o_err, 1'b0);
        check32("hs.rdata", o_rdata, 32'hA0000000 + 32'(c - 3));
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(negedge clk); sample(0);
    check1("hs.end_ready", o_ready, 1'b1);
    check1("hs.end_stall", o_stall, 1'b0);
    check1("hs.end_valid", o_valid, 1'b0);

    // Reset in the first WAIT cycle aborts the store
    do_req(0, 1'b1, 32'h40, 32'd0, 4'hF, 3, 1'b0, 32'd0, "clr40");
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 32'h40, 32'h55, 4'hF);
    @(negedge clk); sample(0);
    check1("abort.acc_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    reset = 1'b1;
    @(negedge clk); sample(0);
    check1("abort.valid", o_valid, 1'b0);
    check1("abort.ready", o_ready, 1'b1);
    check1("abort.stall", o_stall, 1'b0);
    check1("abort.err", o_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); sample(0);
      check1("abort.quiet_valid", o_valid, 1'b0);
      check1("abort.quiet_ready", o_ready, 1'b1);
      @(posedge clk); #1;
    end
    do_req(0, 1'b0, 32'h40, 32'd0, 4'h0, 3, 1'b0, 32'd0, "ld40");

    // Latency boundaries
    do_req(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 2, 1'b0, 32'd0, "l1.st");
    do_req(1, 1'b0, 32'h8, 32'd0, 4'h0, 2, 1'b0, 32'hCAFEF00D, "l1.ld");
    do_req(1, 1'b0, 32'h9, 32'd0, 4'h0, 1, 1'b1, 32'd0, "l1.mis");
    do_req(2, 1'b1, 32'hFFC, 32'h0BADC0DE, 4'hF, 16, 1'b0, 32'd0, "l15.st");
    do_req(2, 1'b0, 32'hFFC, 32'd0, 4'h0, 16, 1'b0, 32'h0BADC0DE, "l15.ld");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
